// File: rtl/adder_hf_1bit_if.sv
// Handshake bundle for adder_hf_1bit: operand side (in_*) and result side (out_*).
// master: the upstream/downstream environment; slave: the adder itself.
interface adder_hf_1bit_if;
    logic in_valid;
    logic in_ready;
    logic in1;
    logic in2;
    logic out_valid;
    logic out_ready;
    logic out;
    logic carry;

    modport master (
        output in_valid,
        input  in_ready,
        output in1,
        output in2,
        input  out_valid,
        output out_ready,
        input  out,
        input  carry
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in1,
        input  in2,
        output out_valid,
        input  out_ready,
        output out,
        output carry
    );
endinterface

// File: rtl/adder_hf_1bit.sv
// Registered 1-bit half adder with valid/ready flow control on both sides.
// sum = in1 ^ in2, carry = in1 & in2, one register stage, 1 pair/cycle.
// Optional feature macro ADDER_HF1BIT_STATS_EN adds a saturating carry_cnt
// counter of accepted operand pairs that produced carry=1.
module adder_hf_1bit
`ifdef ADDER_HF1BIT_STATS_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst_n,
`ifdef ADDER_HF1BIT_STATS_EN
    output logic [CNT_W-1:0] carry_cnt,
`endif
    adder_hf_1bit_if.slave   bus
);

    logic in_rdy;
    logic accept;
    logic vld_q, vld_d;
    logic sum_q, sum_d;
    logic car_q, car_d;

    // Ready whenever the output slot is empty or being drained this cycle.
    assign in_rdy      = !vld_q || bus.out_ready;
    assign accept      = bus.in_valid && in_rdy;
    assign bus.in_ready = in_rdy;

    // Next state: load on accept, clear valid on idle drain, otherwise hold.
    // Operands are only looked at under accept so X on them cannot leak.
    always_comb begin
        vld_d = vld_q;
        sum_d = sum_q;
        car_d = car_q;
        if (accept) begin
            vld_d = 1'b1;
            sum_d = bus.in1 ^ bus.in2;
            car_d = bus.in1 & bus.in2;
        end else if (vld_q && bus.out_ready) begin
            vld_d = 1'b0;
        end
    end

    // Result register; reset discards any pending result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            sum_q <= 1'b0;
            car_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            sum_q <= sum_d;
            car_q <= car_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out       = sum_q;
    assign bus.carry     = car_q;

`ifdef ADDER_HF1BIT_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Count accepted pairs that generate a carry.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && bus.in1 && bus.in2) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // Carry-event counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_adder_hf_1bit.sv
// Self-checking bench for adder_hf_1bit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_adder_hf_1bit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    adder_hf_1bit_if bif ();

`ifdef ADDER_HF1BIT_STATS_EN
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    logic [CNT_W-1:0] carry_cnt;
    adder_hf_1bit #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .carry_cnt (carry_cnt),
        .bus       (bif)
    );
`else
    adder_hf_1bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one-entry result slot described by its contents.
    logic m_vld;
    logic m_sum;
    logic m_car;
    int   m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readiness mid-cycle, advance the
    // model on the edge, then check the registered outputs just after it.
    task automatic cycle(input logic v, input logic a, input logic b,
                         input logic ordy, input logic rstn, input string tag);
        int total;
        bit acc;
        rst_n         = rstn;
        bif.in_valid  = v;
        bif.in1       = a;
        bif.in2       = b;
        bif.out_ready = ordy;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, bif.in_ready}, {31'd0, (!m_vld || ordy)});
        @(posedge clk);
        if (!rstn) begin
            m_vld = 1'b0;
            m_sum = 1'b0;
            m_car = 1'b0;
            m_cnt = 0;
        end else begin
            acc = v && (!m_vld || ordy);
            if (acc) begin
                total = int'(a) + int'(b);
                m_vld = 1'b1;
                m_sum = (total % 2) != 0;
                m_car = (total / 2) != 0;
`ifdef ADDER_HF1BIT_STATS_EN
                if (m_car && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`endif
            end else if (m_vld && ordy) begin
                m_vld = 1'b0;
            end
        end
        #1;
        chk({tag, ".out_valid"}, {31'd0, bif.out_valid}, {31'd0, m_vld});
        chk({tag, ".out"},       {31'd0, bif.out},       {31'd0, m_sum});
        chk({tag, ".carry"},     {31'd0, bif.carry},     {31'd0, m_car});
`ifdef ADDER_HF1BIT_STATS_EN
        chk({tag, ".carry_cnt"}, 32'(carry_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        logic [1:0] pairs [5];
        logic       exp_out [5];
        logic       exp_car [5];
        logic       v, a, b, ordy, rstn;
        checks = 0;
        errors = 0;
        m_vld  = 1'b0;
        m_sum  = 1'b0;
        m_car  = 1'b0;
        m_cnt  = 0;
        rst_n         = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in1       = 1'b0;
        bif.in2       = 1'b0;
        bif.out_ready = 1'b0;

        // Reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst0");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rst1");
        chk("reset.out_valid", {31'd0, bif.out_valid}, 32'd0);

        // Full truth table at full throughput
        pairs   = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        exp_out = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_car = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, pairs[i][1], pairs[i][0], 1'b1, 1'b1, "tt");
            chk("tt.const_out",   {31'd0, bif.out},       {31'd0, exp_out[i]});
            chk("tt.const_carry", {31'd0, bif.carry},     {31'd0, exp_car[i]});
            chk("tt.const_valid", {31'd0, bif.out_valid}, 32'd1);
        end

        // Reset overrides a handshake and discards the pending result
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "rst_mid");
        chk("rst_mid.const_valid", {31'd0, bif.out_valid}, 32'd0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "rst_rel");
        chk("rst_rel.const_valid", {31'd0, bif.out_valid}, 32'd0);

        // Backpressure: 11 held for three stalled cycles, 01 not taken
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "bp_load");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "bp_stall");
            chk("bp.const_out",   {31'd0, bif.out},      32'd0);
            chk("bp.const_carry", {31'd0, bif.carry},    32'd1);
            chk("bp.const_ready", {31'd0, bif.in_ready}, 32'd0);
        end

        // Drain and refill in the same cycle, no bubble
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "refill");
        chk("refill.const_out",   {31'd0, bif.out},       32'd1);
        chk("refill.const_carry", {31'd0, bif.carry},     32'd0);
        chk("refill.const_valid", {31'd0, bif.out_valid}, 32'd1);

        // Idle drain with X on the operands
        cycle(1'b0, 1'bx, 1'bx, 1'b1, 1'b1, "drain");
        chk("drain.const_valid", {31'd0, bif.out_valid}, 32'd0);
        chk("drain.const_out",   {31'd0, bif.out},       32'd1);

`ifdef ADDER_HF1BIT_STATS_EN
        // Saturating carry counter
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sat_rst");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "sat");
            chk("sat.const_cnt", 32'(carry_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
        end
`endif

        // Randomized traffic with occasional resets and X on idle operands
        for (int i = 0; i < 400; i++) begin
            v    = ($urandom_range(0, 3) != 0);
            a    = $urandom_range(0, 1) != 0;
            b    = $urandom_range(0, 1) != 0;
            ordy = ($urandom_range(0, 3) != 0);
            rstn = ($urandom_range(0, 59) != 0);
            if (!v && $urandom_range(0, 1) != 0) begin
                a = 1'bx;
                b = 1'bx;
            end
            cycle(v, a, b, ordy, rstn, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
